// File: rtl/dmem_lsu_ctrl_if.sv
// Request, response and data-memory signals of the load/store sequencer.
// The slave modport is the sequencer; the master side is the execute stage plus memory.
// Handshakes are valid/ready on request and response. The memory side has no flow control.
interface dmem_lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
    // request from execute stage
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    // response to execute stage
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    // byte-write-enabled synchronous data memory
    logic [ADDR_W-1:0] mem_daddr;
    logic [31:0]       mem_indata;
    logic [3:0]        mem_we;
    logic [31:0]       mem_outdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_outdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_daddr, mem_indata, mem_we
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_outdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_daddr, mem_indata, mem_we
    );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// RV32I load/store sequencer: lane-aligns stores, extends loads, and rejects bad accesses.
// Latency from accept to resp_valid is 1 cycle for an error, 2 for a store and 3 for a load.
// Accepts one request at a time. req_ready is low from accept until the response is taken.
module dmem_lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_lsu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LDATA  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    logic        store_q;   // captured request is a store
    logic [2:0]  f3_q;      // captured funct3, selects load extension
    logic [1:0]  off_q;     // byte offset inside the word, used for the load shift

    // request decode
    logic        f3_ok;
    logic        misal;
    logic        req_ok;
    logic [1:0]  eff_off;
    logic [31:0] nxt_indata;
    logic [3:0]  nxt_we;

    // load path
    logic [31:0] shifted;
    logic [31:0] ext_data;

    // Decode the offered request: legality, alignment, lane data and byte enables.
    always_comb begin
        f3_ok      = 1'b0;
        misal      = 1'b0;
        eff_off    = 2'b00;
        nxt_indata = bus.req_wdata;
        nxt_we     = 4'b0000;

        // LBU/LHU have no store counterpart, so funct3 100/101 are legal only for loads
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~bus.req_store;
            default:                f3_ok = 1'b0;
        endcase

        // The effective offset drops the low bits a half or word cannot use. For aligned
        // accesses it equals the address offset. With alignment checking off, it gives the
        // "ignore low bits" behaviour.
        case (bus.req_funct3[1:0])
            2'b00: begin
                eff_off    = bus.req_addr[1:0];
                nxt_indata = {4{bus.req_wdata[7:0]}};
                nxt_we     = 4'b0001 << eff_off;
            end
            2'b01: begin
                misal      = bus.req_addr[0];
                eff_off    = {bus.req_addr[1], 1'b0};
                nxt_indata = {2{bus.req_wdata[15:0]}};
                nxt_we     = 4'b0011 << eff_off;
            end
            default: begin
                misal      = |bus.req_addr[1:0];
                eff_off    = 2'b00;
                nxt_indata = bus.req_wdata;
                nxt_we     = 4'b1111;
            end
        endcase

        // loads never write, whatever the size
        if (!bus.req_store) begin
            nxt_we = 4'b0000;
        end

        req_ok = f3_ok & ~(CHECK_ALIGN & misal);
    end

    // Move the addressed byte or half to bit 0, then sign- or zero-extend it by funct3.
    always_comb begin
        shifted  = bus.mem_outdata >> {off_q, 3'b000};
        ext_data = shifted;
        case (f3_q)
            3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext_data = {24'd0, shifted[7:0]};
            3'b101:  ext_data = {16'd0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    // Sequencer FSM. All outputs are registered, and reset clears any write in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            store_q        <= 1'b0;
            f3_q           <= 3'b000;
            off_q          <= 2'b00;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
            bus.mem_daddr  <= '0;
            bus.mem_indata <= 32'd0;
            bus.mem_we     <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        store_q       <= bus.req_store;
                        f3_q          <= bus.req_funct3;
                        off_q         <= eff_off;
                        if (req_ok) begin
                            state          <= ACCESS;
                            bus.mem_daddr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            bus.mem_indata <= nxt_indata;
                            bus.mem_we     <= nxt_we;
                        end else begin
                            // bad request: report it without any memory cycle
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_rdata <= 32'd0;
                            bus.resp_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // memory samples address and enables at the end of this cycle
                    bus.mem_we <= 4'b0000;
                    if (store_q) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= 32'd0;
                        bus.resp_err   <= 1'b0;
                    end else begin
                        state <= LDATA;
                    end
                end
                LDATA: begin
                    // read data for the ACCESS address is on mem_outdata now
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= ext_data;
                    bus.resp_err   <= 1'b0;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.mem_we     <= 4'b0000;
                end
            endcase
        end
    end

endmodule
